// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port responder with word RAM, LED register and compare/match timer.
// Reads are combinational from ALUResult; writes commit on the rising clock edge.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LED_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      ALUResult,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    output logic [LED_W-1:0] leds,
    output logic             irq
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      count_q, count_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [31:0]      cmp_q, cmp_d;
    logic             match_q, match_d;
    logic             ram_hit, mmio_hit, hit;
    logic [5:0]       off;
    logic [AW-1:0]    widx;
    logic             unused_ok;

    assign unused_ok = ^ALUResult[1:0];
    // High address bits all zero means bit31 clear and word index below DEPTH_WORDS
    assign ram_hit  = ALUResult[31:AW+2] == '0;
    assign mmio_hit = ALUResult[31:8] == 24'h800000;
    assign off      = ALUResult[7:2];
    assign widx     = ALUResult[AW+1:2];
    assign hit      = ctrl_q[0] && count_q == cmp_q;

    always_comb begin
        led_d   = (MemWrite && mmio_hit && off == 6'd0) ? WriteData[LED_W-1:0] : led_q;
        ctrl_d  = (MemWrite && mmio_hit && off == 6'd2) ? WriteData[2:0] : ctrl_q;
        cmp_d   = (MemWrite && mmio_hit && off == 6'd3) ? WriteData : cmp_q;
        count_d = !ctrl_q[0] ? count_q : (hit && ctrl_q[2]) ? 32'h0 : count_q + 32'h1;
        // A match on the same edge as a W1C write keeps MATCH set
        match_d = hit | (match_q & ~(MemWrite && mmio_hit && off == 6'd4 && WriteData[0]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            match_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit) mem_q[widx] <= WriteData;
    end

    always_comb begin
        ReadData = ram_hit ? mem_q[widx] :
                   !mmio_hit ? 32'h0 :
                   off == 6'd0 ? {{(32-LED_W){1'b0}}, led_q} :
                   off == 6'd1 ? count_q :
                   off == 6'd2 ? {29'h0, ctrl_q} :
                   off == 6'd3 ? cmp_q :
                   off == 6'd4 ? {31'h0, match_q} : 32'h0;
    end

    assign leds = led_q;
    assign irq  = match_q & ctrl_q[1];
endmodule
